// File: rtl/ysyx_24110006_pkg.sv
// ysyx_24110006_pkg
// Shared definitions for the load/store unit: FSM state encoding, access size
// encodings, the AXI OKAY response code, and a helper that maps an access to
// its effective byte-lane offset inside a 32-bit word.
package ysyx_24110006_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRaddr,
    StRdata,
    StWrite,
    StWresp,
    StResp
  } lsu_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // Halves force addr[0] low and words force both low bits low, so the
  // datapath always sees a naturally aligned lane.
  function automatic logic [1:0] lane_offset(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [1:0] off;
    case (size)
      SIZE_BYTE: off = addr_lo;
      SIZE_HALF: off = {addr_lo[1], 1'b0};
      default:   off = 2'b00;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/ysyx_24110006_lsu_align.sv
// ysyx_24110006_LSU_ALIGN
// Combinational lane steering for the LSU.
//   i_addr_lo  : low two address bits of the access
//   i_size     : 0 byte, 1 half, 2/3 word
//   i_unsigned : zero-extend loads when 1, sign-extend when 0
//   i_wdata    : right-aligned store data
//   i_rdata    : raw AXI read word
//   o_wdata    : store data shifted onto its byte lanes
//   o_wstrb    : AXI write strobe (upper nibble always 0)
//   o_rdata    : extracted and extended load data
module ysyx_24110006_LSU_ALIGN
  import ysyx_24110006_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_wdata,
  output logic [7:0]  o_wstrb,
  output logic [31:0] o_rdata
);

  logic [1:0]  w_off;
  logic [3:0]  w_strb_base;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_off = lane_offset(i_size, i_addr_lo);

    case (i_size)
      SIZE_BYTE: w_strb_base = 4'b0001;
      SIZE_HALF: w_strb_base = 4'b0011;
      default:   w_strb_base = 4'b1111;
    endcase

    o_wdata = i_wdata << {w_off, 3'b000};
    o_wstrb = {4'b0000, w_strb_base << w_off};

    w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];

    case (i_size)
      SIZE_BYTE: o_rdata = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SIZE_HALF: o_rdata = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default:   o_rdata = i_rdata;
    endcase
  end

endmodule

// File: rtl/ysyx_24110006_lsu.sv
// ysyx_24110006_lsu
// Single-outstanding load/store unit bridging a valid/ready core request port
// to an AXI-lite master (32-bit address and data).
//   i_clock, i_reset       : clock, synchronous active-high reset
//   i_req_*, o_req_ready   : core request (wen, addr, wdata, size, unsigned)
//   o_resp_*, i_resp_ready : core response (rdata, err)
//   o_axi_* / i_axi_*      : AXI-lite AR, R, AW, W and B channels
// Build option: YSYX_24110006_MISALIGN_CHECK_EN -- when defined, misaligned
// half/word accesses skip the bus and return an error response. Otherwise the
// low address bits are ignored to force natural alignment.
module ysyx_24110006_lsu
  import ysyx_24110006_pkg::*;
(
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_wen,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic [31:0] o_axi_araddr,
  output logic        o_axi_arvalid,
  input  logic        i_axi_arready,
  input  logic [31:0] i_axi_rdata,
  input  logic        i_axi_rvalid,
  input  logic [1:0]  i_axi_rresp,
  output logic        o_axi_rready,
  output logic [31:0] o_axi_awaddr,
  output logic        o_axi_awvalid,
  input  logic        i_axi_awready,
  output logic [31:0] o_axi_wdata,
  output logic [7:0]  o_axi_wstrb,
  output logic        o_axi_wvalid,
  input  logic        i_axi_wready,
  input  logic [1:0]  i_axi_bresp,
  input  logic        i_axi_bvalid,
  output logic        o_axi_bready
);

  lsu_state_e  r_state;
  lsu_state_e  w_state_next;

  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_axi_wdata;
  logic [7:0]  r_axi_wstrb;
  logic        r_aw_done;
  logic        r_w_done;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_misalign;
  logic [1:0]  w_al_addr_lo;
  logic [1:0]  w_al_size;
  logic [31:0] w_al_wdata;
  logic [7:0]  w_al_wstrb;
  logic [31:0] w_al_rdata;

  assign w_accept = (r_state == StIdle) && i_req_valid;

`ifdef YSYX_24110006_MISALIGN_CHECK_EN
  assign w_misalign = ((i_req_size == SIZE_HALF) && i_req_addr[0]) ||
                      (i_req_size[1] && (i_req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  // Store lanes are computed from the live request at acceptance; load
  // extraction runs later against the latched request.
  assign w_al_addr_lo = (r_state == StIdle) ? i_req_addr[1:0] : r_addr[1:0];
  assign w_al_size    = (r_state == StIdle) ? i_req_size : r_size;

  ysyx_24110006_LSU_ALIGN u_align (
    .i_addr_lo  (w_al_addr_lo),
    .i_size     (w_al_size),
    .i_unsigned (r_unsigned),
    .i_wdata    (i_req_wdata),
    .i_rdata    (i_axi_rdata),
    .o_wdata    (w_al_wdata),
    .o_wstrb    (w_al_wstrb),
    .o_rdata    (w_al_rdata)
  );

  assign o_axi_araddr = {r_addr[31:2], 2'b00};
  assign o_axi_awaddr = {r_addr[31:2], 2'b00};
  assign o_axi_wdata  = r_axi_wdata;
  assign o_axi_wstrb  = r_axi_wstrb;
  assign o_resp_rdata = r_rdata;
  assign o_resp_err   = r_err;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    o_req_ready   = 1'b0;
    o_resp_valid  = 1'b0;
    o_axi_arvalid = 1'b0;
    o_axi_rready  = 1'b0;
    o_axi_awvalid = 1'b0;
    o_axi_wvalid  = 1'b0;
    o_axi_bready  = 1'b0;
    case (r_state)
      StIdle: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          if (w_misalign)     w_state_next = StResp;
          else if (i_req_wen) w_state_next = StWrite;
          else                w_state_next = StRaddr;
        end
      end
      StRaddr: begin
        o_axi_arvalid = 1'b1;
        if (i_axi_arready) w_state_next = StRdata;
      end
      StRdata: begin
        o_axi_rready = 1'b1;
        if (i_axi_rvalid) w_state_next = StResp;
      end
      StWrite: begin
        o_axi_awvalid = !r_aw_done;
        o_axi_wvalid  = !r_w_done;
        // AW and W complete independently; leave once both have been taken.
        if ((r_aw_done || i_axi_awready) && (r_w_done || i_axi_wready)) begin
          w_state_next = StWresp;
        end
      end
      StWresp: begin
        o_axi_bready = 1'b1;
        if (i_axi_bvalid) w_state_next = StResp;
      end
      StResp: begin
        o_resp_valid = 1'b1;
        if (i_resp_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_addr      <= 32'h0;
      r_size      <= 2'b00;
      r_unsigned  <= 1'b0;
      r_axi_wdata <= 32'h0;
      r_axi_wstrb <= 8'h00;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_rdata     <= 32'h0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_addr      <= i_req_addr;
            r_size      <= i_req_size;
            r_unsigned  <= i_req_unsigned;
            r_axi_wdata <= i_req_wen ? w_al_wdata : 32'h0;
            r_axi_wstrb <= i_req_wen ? w_al_wstrb : 8'h00;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_rdata     <= 32'h0;
            r_err       <= w_misalign;
          end
        end
        StRdata: begin
          if (i_axi_rvalid) begin
            r_rdata <= w_al_rdata;
            r_err   <= (i_axi_rresp != AXI_RESP_OKAY);
          end
        end
        StWrite: begin
          if (o_axi_awvalid && i_axi_awready) r_aw_done <= 1'b1;
          if (o_axi_wvalid && i_axi_wready)   r_w_done  <= 1'b1;
        end
        StWresp: begin
          if (i_axi_bvalid) begin
            r_rdata <= 32'h0;
            r_err   <= (i_axi_bresp != AXI_RESP_OKAY);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24110006_lsu.sv
module tb_ysyx_24110006_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen, req_uns;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready;
  logic        bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [7:0]  wstrb;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ysyx_24110006_lsu dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_wen      (req_wen),
    .i_req_addr     (req_addr),
    .i_req_wdata    (req_wdata),
    .i_req_size     (req_size),
    .i_req_unsigned (req_uns),
    .o_resp_valid   (resp_valid),
    .i_resp_ready   (resp_ready),
    .o_resp_rdata   (resp_rdata),
    .o_resp_err     (resp_err),
    .o_axi_araddr   (araddr),
    .o_axi_arvalid  (arvalid),
    .i_axi_arready  (arready),
    .i_axi_rdata    (rdata),
    .i_axi_rvalid   (rvalid),
    .i_axi_rresp    (rresp),
    .o_axi_rready   (rready),
    .o_axi_awaddr   (awaddr),
    .o_axi_awvalid  (awvalid),
    .i_axi_awready  (awready),
    .o_axi_wdata    (wdata),
    .o_axi_wstrb    (wstrb),
    .o_axi_wvalid   (wvalid),
    .i_axi_wready   (wready),
    .i_axi_bresp    (bresp),
    .i_axi_bvalid   (bvalid),
    .o_axi_bready   (bready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] wd);
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_size  = size;
    req_uns   = uns;
    req_wdata = wd;
  endtask

  // Scramble request fields after acceptance so latching is exercised.
  task automatic drop_req();
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'hFFFF_FFFF;
    req_size  = 2'd3;
    req_uns   = ~req_uns;
  endtask

  // Zero-wait-slave load; response is held unacknowledged for `hold` cycles.
  task automatic t_load(input string nm, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] rd, input logic [1:0] rr,
                        input logic [31:0] exp_data, input logic exp_err, input int hold);
    logic [31:0] exp_ar;
    exp_ar = {addr[31:2], 2'b00};
    @(negedge clk);
    chk({nm, ".req_ready"}, req_ready, 1);
    drive_req(1'b0, addr, size, uns, 32'h5A5A_5A5A);
    @(negedge clk);
    drop_req();
    chk({nm, ".arvalid"}, arvalid, 1);
    chk({nm, ".araddr"}, araddr, exp_ar);
    chk({nm, ".rready_early"}, rready, 0);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    chk({nm, ".arvalid_drop"}, arvalid, 0);
    chk({nm, ".rready"}, rready, 1);
    chk({nm, ".resp_early"}, resp_valid, 0);
    rvalid = 1'b1;
    rdata  = rd;
    rresp  = rr;
    @(negedge clk);
    rvalid = 1'b0;
    rdata  = 32'h0;
    rresp  = 2'b00;
    chk({nm, ".resp_valid"}, resp_valid, 1);
    chk({nm, ".rdata"}, resp_rdata, exp_data);
    chk({nm, ".err"}, resp_err, exp_err);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, ".hold_valid"}, resp_valid, 1);
      chk({nm, ".hold_rdata"}, resp_rdata, exp_data);
      chk({nm, ".hold_err"}, resp_err, exp_err);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({nm, ".resp_done"}, resp_valid, 0);
    chk({nm, ".idle_ready"}, req_ready, 1);
  endtask

  // Zero-wait-slave store with AW and W accepted together.
  task automatic t_store(input string nm, input logic [31:0] addr, input logic [1:0] size,
                         input logic [31:0] wd, input logic [1:0] br,
                         input logic [31:0] exp_aw, input logic [31:0] exp_wd,
                         input logic [7:0] exp_strb, input logic exp_err);
    @(negedge clk);
    chk({nm, ".req_ready"}, req_ready, 1);
    drive_req(1'b1, addr, size, 1'b0, wd);
    @(negedge clk);
    drop_req();
    chk({nm, ".awvalid"}, awvalid, 1);
    chk({nm, ".wvalid"}, wvalid, 1);
    chk({nm, ".arvalid"}, arvalid, 0);
    chk({nm, ".awaddr"}, awaddr, exp_aw);
    chk({nm, ".wdata"}, wdata, exp_wd);
    chk({nm, ".wstrb"}, wstrb, exp_strb);
    awready = 1'b1;
    wready  = 1'b1;
    @(negedge clk);
    awready = 1'b0;
    wready  = 1'b0;
    chk({nm, ".awvalid_drop"}, awvalid, 0);
    chk({nm, ".wvalid_drop"}, wvalid, 0);
    chk({nm, ".bready"}, bready, 1);
    bvalid = 1'b1;
    bresp  = br;
    @(negedge clk);
    bvalid = 1'b0;
    bresp  = 2'b00;
    chk({nm, ".resp_valid"}, resp_valid, 1);
    chk({nm, ".rdata"}, resp_rdata, 0);
    chk({nm, ".err"}, resp_err, exp_err);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({nm, ".resp_done"}, resp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0; req_size = 0; req_uns = 0;
    resp_ready = 0; arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;

    repeat (2) @(negedge clk);
    chk("rst.arvalid", arvalid, 0);
    chk("rst.rready", rready, 0);
    chk("rst.awvalid", awvalid, 0);
    chk("rst.wvalid", wvalid, 0);
    chk("rst.bready", bready, 0);
    chk("rst.resp_valid", resp_valid, 0);
    chk("rst.resp_err", resp_err, 0);
    chk("rst.resp_rdata", resp_rdata, 0);
    chk("rst.araddr", araddr, 0);
    chk("rst.awaddr", awaddr, 0);
    chk("rst.wdata", wdata, 0);
    chk("rst.wstrb", wstrb, 0);
    rst = 1'b0;

    // Stray R/B beats while idle must not produce a response.
    rvalid = 1'b1;
    bvalid = 1'b1;
    repeat (2) @(negedge clk);
    chk("stray.resp_valid", resp_valid, 0);
    chk("stray.req_ready", req_ready, 1);
    rvalid = 1'b0;
    bvalid = 1'b0;

    t_load("ld_word", 32'h8000_0004, 2'd2, 1'b0, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 1'b0, 0);
    t_load("ld_byte_s", 32'h8000_0003, 2'd0, 1'b0, 32'h8011_2233, 2'b00, 32'hFFFF_FF80, 1'b0, 0);
    t_load("ld_byte_u", 32'h8000_0003, 2'd0, 1'b1, 32'h8011_2233, 2'b00, 32'h0000_0080, 1'b0, 0);
    t_load("ld_half_u", 32'h8000_0002, 2'd1, 1'b1, 32'h8011_2233, 2'b00, 32'h0000_8011, 1'b0, 0);
    t_load("ld_half_s", 32'h8000_0002, 2'd1, 1'b0, 32'h8011_2233, 2'b00, 32'hFFFF_8011, 1'b0, 0);
    t_load("ld_byte1_s", 32'h8000_0001, 2'd0, 1'b0, 32'h8011_2233, 2'b00, 32'h0000_0022, 1'b0, 0);
    t_load("ld_err", 32'h8000_0008, 2'd2, 1'b0, 32'h1234_5678, 2'b10, 32'h1234_5678, 1'b1, 4);

    t_store("st_byte", 32'h8000_0001, 2'd0, 32'h0000_00A5, 2'b00,
            32'h8000_0000, 32'h0000_A500, 8'h02, 1'b0);
    t_store("st_word", 32'h8000_0010, 2'd2, 32'h1234_5678, 2'b00,
            32'h8000_0010, 32'h1234_5678, 8'h0F, 1'b0);
    t_store("st_err", 32'h8000_000C, 2'd2, 32'hCAFE_F00D, 2'b11,
            32'h8000_000C, 32'hCAFE_F00D, 8'h0F, 1'b1);

    // Half store with AW accepted three cycles after W.
    @(negedge clk);
    drive_req(1'b1, 32'h8000_0002, 2'd1, 1'b0, 32'h0000_ABCD);
    @(negedge clk);
    drop_req();
    chk("sth.awvalid", awvalid, 1);
    chk("sth.wvalid", wvalid, 1);
    chk("sth.awaddr", awaddr, 32'h8000_0000);
    chk("sth.wdata", wdata, 32'hABCD_0000);
    chk("sth.wstrb", wstrb, 8'h0C);
    wready = 1'b1;
    @(negedge clk);
    wready = 1'b0;
    chk("sth.w_drop", wvalid, 0);
    chk("sth.aw_hold1", awvalid, 1);
    chk("sth.bready_early", bready, 0);
    @(negedge clk);
    chk("sth.aw_hold2", awvalid, 1);
    chk("sth.w_stay_low", wvalid, 0);
    @(negedge clk);
    chk("sth.aw_hold3", awvalid, 1);
    awready = 1'b1;
    @(negedge clk);
    awready = 1'b0;
    chk("sth.aw_drop", awvalid, 0);
    chk("sth.bready", bready, 1);
    bvalid = 1'b1;
    bresp  = 2'b00;
    @(negedge clk);
    chk("sth.resp_valid", resp_valid, 1);
    chk("sth.err", resp_err, 0);
    chk("sth.bready_once", bready, 0);
    resp_ready = 1'b1;
    @(negedge clk);
    bvalid     = 1'b0;
    resp_ready = 1'b0;
    chk("sth.resp_done", resp_valid, 0);
    @(negedge clk);
    chk("sth.single_resp", resp_valid, 0);

`ifdef YSYX_24110006_MISALIGN_CHECK_EN
    @(negedge clk);
    drive_req(1'b1, 32'h8000_0001, 2'd2, 1'b0, 32'h1122_3344);
    @(negedge clk);
    drop_req();
    chk("mis.awvalid", awvalid, 0);
    chk("mis.wvalid", wvalid, 0);
    chk("mis.arvalid", arvalid, 0);
    chk("mis.resp_valid", resp_valid, 1);
    chk("mis.err", resp_err, 1);
    chk("mis.rdata", resp_rdata, 0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("mis.resp_done", resp_valid, 0);
`else
    t_store("mis_st_word", 32'h8000_0001, 2'd2, 32'h1122_3344, 2'b00,
            32'h8000_0000, 32'h1122_3344, 8'h0F, 1'b0);
    t_load("mis_ld_half", 32'h8000_0003, 2'd1, 1'b1, 32'h8011_2233, 2'b00,
           32'h0000_8011, 1'b0, 0);
`endif

    // Reset while waiting for read data abandons the load.
    @(negedge clk);
    drive_req(1'b0, 32'h8000_0020, 2'd2, 1'b0, 32'h0);
    @(negedge clk);
    drop_req();
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    chk("rstmid.in_rdata", rready, 1);
    rst    = 1'b1;
    rvalid = 1'b1;
    rdata  = 32'h0BAD_0BAD;
    @(negedge clk);
    rst    = 1'b0;
    rvalid = 1'b0;
    chk("rstmid.arvalid", arvalid, 0);
    chk("rstmid.rready", rready, 0);
    chk("rstmid.awvalid", awvalid, 0);
    chk("rstmid.wvalid", wvalid, 0);
    chk("rstmid.bready", bready, 0);
    chk("rstmid.resp_valid", resp_valid, 0);
    chk("rstmid.req_ready", req_ready, 1);
    chk("rstmid.araddr", araddr, 0);
    @(negedge clk);
    chk("rstmid.no_resp", resp_valid, 0);

    t_load("ld_after_rst", 32'h8000_0008, 2'd2, 1'b0, 32'h0F0F_1234, 2'b00,
           32'h0F0F_1234, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
